// File: rtl/sram_bus_responder_if.sv
// CPU-side asynchronous-SRAM-style bus: active-low strobes, 20-bit word address,
// 16-bit data, plus the responder's Ready/Err completion signals.
interface sram_bus_responder_if;
  logic        CE;
  logic        OE;
  logic        WE;
  logic        UB;
  logic        LB;
  logic [19:0] A;
  logic [15:0] Data_from_cpu;
  logic [15:0] Data_to_cpu;
  logic        Ready;
  logic        Err;

  modport master (
    output CE, OE, WE, UB, LB, A, Data_from_cpu,
    input  Data_to_cpu, Ready, Err
  );

  modport slave (
    input  CE, OE, WE, UB, LB, A, Data_from_cpu,
    output Data_to_cpu, Ready, Err
  );
endinterface

// File: rtl/sram_bus_responder.sv
// SRAM-bus responder backed by an on-chip word RAM, with programmable wait states.
// Optional write protection below PROT_LIMIT: define SRAM_BUS_RESPONDER_PROTECT_EN.
module sram_bus_responder #(
  parameter int          ADDR_BITS   = 10,
  parameter int          WAIT_STATES = 2,
  parameter logic [15:0] MISS_DATA   = 16'hDEAD,
  parameter int          PROT_LIMIT  = 16
) (
  input logic               Clk,
  input logic               Reset,
  sram_bus_responder_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  localparam logic [3:0] LAST_WAIT = 4'(WAIT_STATES - 1);

  state_t          state_q, state_d;
  logic [3:0]      wait_cnt_q, wait_cnt_d;
  logic [19:0]     addr_q;
  logic            write_q;
  logic            ub_en_q;
  logic            lb_en_q;
  logic [15:0]     wdata_q;
  logic [15:0]     rdata_q, rdata_d;
  logic            ready_q, ready_d;

  logic            req;
  logic            capture;
  logic            in_range;
  logic            protected_wr;
  logic            mem_we;
  logic [15:0]     rd_word;
  logic [ADDR_BITS-1:0] idx;

  logic [15:0] mem [0:(1<<ADDR_BITS)-1];

  assign req     = !bus.CE && (!bus.WE || !bus.OE);
  assign capture = (state_q == S_IDLE) && req;
  assign idx     = addr_q[ADDR_BITS-1:0];

  generate
    if (ADDR_BITS < 20) begin : g_decode
      assign in_range = (addr_q[19:ADDR_BITS] == '0);
    end else begin : g_full_decode
      assign in_range = 1'b1;
    end
  endgenerate

`ifdef SRAM_BUS_RESPONDER_PROTECT_EN
  logic err_q, err_d;

  assign protected_wr = in_range && (addr_q < 20'(PROT_LIMIT));
  assign err_d        = (state_q == S_ACCESS) && write_q && protected_wr;
  assign bus.Err      = err_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`else
  logic unused_prot_limit;

  assign protected_wr      = 1'b0;
  assign unused_prot_limit = (PROT_LIMIT != 0);
  assign bus.Err           = 1'b0;
`endif

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic; only withdrawal of the request is observed after capture
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          wait_cnt_d = '0;
          state_d    = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (bus.CE)                       state_d = S_IDLE;
        else if (wait_cnt_q == LAST_WAIT) state_d = S_ACCESS;
        else                              wait_cnt_d = wait_cnt_q + 4'd1;
      end
      S_ACCESS: state_d = S_DONE;
      S_DONE: begin
        if (bus.CE || (bus.OE && bus.WE)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    rd_word = in_range ? mem[idx] : MISS_DATA;
    ready_d = (state_d == S_DONE);
    rdata_d = rdata_q;
    mem_we  = (state_q == S_ACCESS) && write_q && in_range && !protected_wr;
    if ((state_q == S_ACCESS) && !write_q) begin
      rdata_d = {ub_en_q ? rd_word[15:8] : 8'h00,
                 lb_en_q ? rd_word[7:0]  : 8'h00};
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      ub_en_q <= 1'b0;
      lb_en_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      if (capture) begin
        addr_q  <= bus.A;
        write_q <= !bus.WE;
        ub_en_q <= !bus.UB;
        lb_en_q <= !bus.LB;
        wdata_q <= bus.Data_from_cpu;
      end
      rdata_q <= rdata_d;
      ready_q <= ready_d;
    end
  end

  // RAM contents survive reset, so this block has no reset term
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      if (ub_en_q) mem[idx][15:8] <= wdata_q[15:8];
      if (lb_en_q) mem[idx][7:0]  <= wdata_q[7:0];
    end
  end

  assign bus.Ready       = ready_q;
  assign bus.Data_to_cpu = rdata_q;

endmodule

// File: tb/tb_sram_bus_responder.sv
// Directed bench for sram_bus_responder: stimulus pushes expectations, a
// negedge monitor pops and compares them whenever Ready rises.
module tb_sram_bus_responder;

  localparam int W = 2;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;

  sram_bus_responder_if bus ();

  sram_bus_responder #(
    .ADDR_BITS  (10),
    .WAIT_STATES(W),
    .MISS_DATA  (16'hDEAD),
    .PROT_LIMIT (16)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        chk_data;
    logic        neq;
    logic [15:0] data;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic ready_prev = 1'b0;

`ifdef SRAM_BUS_RESPONDER_PROTECT_EN
  localparam logic PROT = 1'b1;
`else
  localparam logic PROT = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Scoreboard monitor
  always @(negedge Clk) begin
    exp_t e;
    if (bus.Ready === 1'b1 && ready_prev !== 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready actual=1 required=0");
      end else begin
        e = sb.pop_front();
        if (e.chk_data) begin
          if (e.neq) begin
            checks++;
            if (bus.Data_to_cpu === e.data) begin
              errors++;
              $display("FAIL %s_data actual=%h required=not_%h", e.name, bus.Data_to_cpu, e.data);
            end
          end else begin
            chk({e.name, "_data"}, 32'(bus.Data_to_cpu), 32'(e.data));
          end
        end
        chk({e.name, "_err"}, 32'(bus.Err), 32'(e.err));
        $display("txn %s data=%h err=%b", e.name, bus.Data_to_cpu, bus.Err);
      end
    end
    ready_prev = bus.Ready;
  end

  task automatic bus_idle();
    bus.CE = 1'b1; bus.OE = 1'b1; bus.WE = 1'b1;
    bus.UB = 1'b1; bus.LB = 1'b1;
  endtask

  // ub/lb are the active-low lane strobes as driven on the bus
  task automatic access(input logic wr, input logic ub, input logic lb,
                        input logic [19:0] a, input logic [15:0] wd,
                        input logic [15:0] exp_d, input logic exp_err,
                        input logic neq, input logic wiggle, input string name);
    exp_t e;
    int   cnt;
    e.chk_data = !wr; e.neq = neq; e.data = exp_d; e.err = exp_err; e.name = name;
    sb.push_back(e);
    bus.CE = 1'b0; bus.WE = !wr; bus.OE = wr;
    bus.UB = ub; bus.LB = lb; bus.A = a; bus.Data_from_cpu = wd;
    @(posedge Clk); #1;
    if (wiggle) begin
      bus.A = a ^ 20'h00001;
      bus.Data_from_cpu = ~wd;
    end
    cnt = 0;
    while (bus.Ready !== 1'b1 && cnt < 40) begin
      @(posedge Clk); #1;
      cnt++;
    end
    chk({name, "_latency"}, 32'(cnt), 32'(W + 1));
    @(posedge Clk); #1;
    chk({name, "_ready_hold"}, 32'(bus.Ready), 32'd1);
    chk({name, "_err_pulse_end"}, 32'(bus.Err), 32'd0);
    bus_idle();
    @(posedge Clk); #1;
    chk({name, "_ready_drop"}, 32'(bus.Ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_idle();
    bus.A = '0;
    bus.Data_from_cpu = '0;
    #1;
    chk("rst_ready", 32'(bus.Ready), 32'd0);
    chk("rst_data", 32'(bus.Data_to_cpu), 32'h0);
    chk("rst_err", 32'(bus.Err), 32'd0);
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk); #1;
      chk("idle_ready", 32'(bus.Ready), 32'd0);
    end
    chk("idle_data", 32'(bus.Data_to_cpu), 32'h0);

    access(1, 0, 0, 20'h00040, 16'h10E1, 16'h0000, 0, 0, 0, "wr40");
    access(0, 0, 0, 20'h00040, 16'h0000, 16'h10E1, 0, 0, 0, "rd40");
    access(1, 1, 1, 20'h00040, 16'h0000, 16'h0000, 0, 0, 0, "wr40_nolane");
    access(0, 0, 0, 20'h00040, 16'h0000, 16'h10E1, 0, 0, 0, "rd40_again");

    access(1, 0, 0, 20'h00041, 16'h5566, 16'h0000, 0, 0, 0, "wr41");
    access(1, 1, 0, 20'h00041, 16'hAB12, 16'h0000, 0, 0, 0, "wr41_lb");
    access(0, 0, 0, 20'h00041, 16'h0000, 16'h5512, 0, 0, 0, "rd41");
    access(0, 0, 1, 20'h00041, 16'h0000, 16'h5500, 0, 0, 0, "rd41_ub");
    access(0, 1, 0, 20'h00041, 16'h0000, 16'h0012, 0, 0, 0, "rd41_lb");
    access(0, 1, 1, 20'h00041, 16'h0000, 16'h0000, 0, 0, 0, "rd41_none");

    access(1, 0, 0, 20'h00000, 16'h0F0F, 16'h0000, 0, 0, 0, "wr00");
    access(0, 0, 0, 20'h80000, 16'h0000, 16'hDEAD, 0, 0, 0, "rd_miss");
    access(0, 1, 0, 20'h80000, 16'h0000, 16'h00AD, 0, 0, 0, "rd_miss_lb");
    access(1, 0, 0, 20'h80000, 16'h1234, 16'h0000, 0, 0, 0, "wr_miss");
    access(0, 0, 0, 20'h00000, 16'h0000, 16'h0F0F, 0, 0, 0, "rd00_alias");
    access(0, 0, 1, 20'h80000, 16'h0000, 16'hDE00, 0, 0, 0, "rd_miss_ub");

    access(0, 0, 0, 20'h00040, 16'h0000, 16'h10E1, 0, 0, 1, "rd40_wiggle");

    // Aborted write: CE withdrawn during WAIT
    access(1, 0, 0, 20'h00050, 16'h7777, 16'h0000, 0, 0, 0, "wr50");
    bus.CE = 1'b0; bus.WE = 1'b0; bus.OE = 1'b1; bus.UB = 1'b0; bus.LB = 1'b0;
    bus.A = 20'h00050; bus.Data_from_cpu = 16'h9999;
    @(posedge Clk); #1;
    bus_idle();
    for (int i = 0; i < 6; i++) begin
      @(posedge Clk); #1;
      chk("abort_ready", 32'(bus.Ready), 32'd0);
    end
    access(0, 0, 0, 20'h00050, 16'h0000, 16'h7777, 0, 0, 0, "rd50");

    // Reset during WAIT must not commit the write
    access(1, 0, 0, 20'h00060, 16'hAAAA, 16'h0000, 0, 0, 0, "wr60");
    bus.CE = 1'b0; bus.WE = 1'b0; bus.OE = 1'b1; bus.UB = 1'b0; bus.LB = 1'b0;
    bus.A = 20'h00060; bus.Data_from_cpu = 16'h5555;
    @(posedge Clk); #1;
    Reset = 1'b0;
    #1;
    chk("midrst_ready", 32'(bus.Ready), 32'd0);
    chk("midrst_data", 32'(bus.Data_to_cpu), 32'h0);
    bus_idle();
    repeat (4) @(posedge Clk);
    #1 Reset = 1'b1;
    repeat (3) begin
      @(posedge Clk); #1;
      chk("postrst_ready", 32'(bus.Ready), 32'd0);
    end
    access(0, 0, 0, 20'h00060, 16'h0000, 16'hAAAA, 0, 0, 0, "rd60");

    access(1, 0, 0, 20'h00003, 16'hFFFF, 16'h0000, PROT, 0, 0, "wr03");
    access(0, 0, 0, 20'h00003, 16'h0000, 16'hFFFF, 0, PROT, 0, "rd03");
    access(1, 0, 0, 20'h00010, 16'h2468, 16'h0000, 0, 0, 0, "wr10");
    access(0, 0, 0, 20'h00010, 16'h0000, 16'h2468, 0, 0, 0, "rd10");

    repeat (3) @(posedge Clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
